inst_fetch: RTL and testbench



---
 rtl/rv32_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 81 ++++++++
 rtl/inst_fetch.sv | 104 ++++++++++
 tb/tb_inst_fetch.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared rv32 constants and the fetch-buffer entry type.
package rv32_pkg;

    localparam int XLEN   = 32;
    localparam int INST_W = 32;

    localparam logic [XLEN-1:0]   RESET_PC_DEFAULT = 32'h0000_0000;
    // Canonical addi x0,x0,0; decode injects it on bubbles.
    localparam logic [INST_W-1:0] NOP_INST         = 32'h0000_0013;

    // One buffered fetch: the instruction and the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    localparam int FETCH_ENTRY_W = XLEN + INST_W;

    // Jump targets must be word aligned; stray low bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush and an occupancy count.
// DEPTH must be a power of two so the pointers wrap for free.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic pop_ok;
    logic push_ok;

    assign pop_ok  = pop & (count_q != '0);
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign push_ok = push & ((count_q != FULL_CNT) | pop_ok);

    // Next-state for pointers, count and storage; flush overrides everything.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage needs no reset; count gates every read of it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, ROM issue, redirect handling and the
// instruction buffer feeding decode over valid/ready.
module inst_fetch
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_req,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_rdata,
    input  logic        jump_en,
    input  logic [31:0] jump_addr,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    input  logic        id_ready
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;
    localparam logic [OCC_W-1:0] OCC_LIMIT = OCC_W'(DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;

    logic             pop;
    logic             push;
    logic [CNT_W-1:0] fifo_count;
    logic [OCC_W-1:0] occupancy;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;
    logic [FETCH_ENTRY_W-1:0] head_raw;

    assign if_valid = (fifo_count != '0);
    assign pop      = if_valid & id_ready;

    // Slots that will be taken once the in-flight word lands, net of this cycle's pop.
    // Never negative: pop implies at least one buffered entry.
    assign occupancy = {1'b0, fifo_count}
                     + {{CNT_W{1'b0}}, inflight_q}
                     - {{CNT_W{1'b0}}, pop};

    assign rom_req  = !rst & !jump_en & (occupancy < OCC_LIMIT);
    assign rom_addr = pc_q;

    // A redirect kills the word returning this cycle.
    assign push       = inflight_q & !jump_en;
    assign push_entry = '{pc: req_pc_q, inst: rom_rdata};

    // PC advance / redirect and tracking of the outstanding ROM read.
    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = rom_req;
        if (jump_en) begin
            pc_d = word_align(jump_addr);
        end else if (rom_req) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
        end
    end

    // Fetch state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            inflight_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    sync_fifo #(
        .WIDTH (FETCH_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (jump_en),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head_raw),
        .count     (fifo_count)
    );

    assign head_entry = fetch_entry_t'(head_raw);
    assign if_inst    = head_entry.inst;
    assign if_pc      = head_entry.pc;

    // The issue rule reserves a slot for every outstanding read.
    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (rst)
        !(push && (fifo_count == CNT_W'(DEPTH)))
    );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a one-cycle-latency ROM model.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic [31:0] rom_rdata;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_ready;

    int n_checks = 0;
    int n_fail   = 0;

    inst_fetch #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rom_req   (rom_req),
        .rom_addr  (rom_addr),
        .rom_rdata (rom_rdata),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .if_valid  (if_valid),
        .if_inst   (if_inst),
        .if_pc     (if_pc),
        .id_ready  (id_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM contents: 0x11..0x44 at 0x0..0xC, otherwise a tag derived from the address.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0000_0011;
            32'h0000_0004: return 32'h0000_0022;
            32'h0000_0008: return 32'h0000_0033;
            32'h0000_000C: return 32'h0000_0044;
            default:       return {8'hC0, a[23:0]};
        endcase
    endfunction

    always @(posedge clk) begin
        if (rom_req) rom_rdata <= rom_word(rom_addr);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one cycle, then drive this cycle's inputs and let logic settle.
    task automatic step(input logic r, input logic rdy, input logic jen, input logic [31:0] jaddr);
        @(posedge clk);
        #1;
        rst       = r;
        id_ready  = rdy;
        jump_en   = jen;
        jump_addr = jaddr;
        #1;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc, input logic [31:0] inst);
        check_eq({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
        check_eq({tag, "_pc"},    if_pc,   pc);
        check_eq({tag, "_inst"},  if_inst, inst);
    endtask

    initial begin
        rst       = 1'b1;
        id_ready  = 1'b0;
        jump_en   = 1'b0;
        jump_addr = 32'd0;
        rom_rdata = 32'd0;

        // Reset state
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check_eq("rst_valid",   {31'd0, if_valid}, 32'd0);
        check_eq("rst_req",     {31'd0, rom_req},  32'd0);
        check_eq("rst_addr",    rom_addr,          32'h0);
        check_eq("rst_count",   32'(dut.fifo_count), 32'd0);

        // Streaming: latency 2, then one instruction per cycle
        step(0, 1, 0, 0);                                   // cycle 0
        check_eq("c0_req",  {31'd0, rom_req}, 32'd1);
        check_eq("c0_addr", rom_addr, 32'h0);
        step(0, 1, 0, 0);                                   // cycle 1
        check_eq("c1_valid", {31'd0, if_valid}, 32'd0);
        check_eq("c1_addr",  rom_addr, 32'h4);
        step(0, 1, 0, 0);                                   // cycle 2
        expect_head("s_c2", 32'h0, 32'h11);
        step(0, 1, 0, 0);
        expect_head("s_c3", 32'h4, 32'h22);
        step(0, 1, 0, 0);
        expect_head("s_c4", 32'h8, 32'h33);
        step(0, 1, 0, 0);
        expect_head("s_c5", 32'hC, 32'h44);

        // Decode stall from cycle 2 for five cycles
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);                                   // cycle 0
        step(0, 1, 0, 0);                                   // cycle 1
        step(0, 0, 0, 0);                                   // cycle 2
        check_eq("st_c2_req", {31'd0, rom_req}, 32'd0);
        for (int i = 3; i <= 6; i++) begin
            step(0, 0, 0, 0);
            check_eq($sformatf("st_c%0d_count", i), 32'(dut.fifo_count), 32'd2);
            check_eq($sformatf("st_c%0d_req", i),   {31'd0, rom_req}, 32'd0);
            check_eq($sformatf("st_c%0d_pc", i),    if_pc, 32'h0);
        end
        step(0, 1, 0, 0);                                   // release
        check_eq("st_rel_req",  {31'd0, rom_req}, 32'd1);
        check_eq("st_rel_addr", rom_addr, 32'h8);
        expect_head("st_r0", 32'h0, 32'h11);
        step(0, 1, 0, 0);
        expect_head("st_r1", 32'h4, 32'h22);
        step(0, 1, 0, 0);
        expect_head("st_r2", 32'h8, 32'h33);
        step(0, 1, 0, 0);
        expect_head("st_r3", 32'hC, 32'h44);

        // Redirect with one entry buffered and a read in flight
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);                                   // cycle 0: req pc 0
        step(0, 0, 0, 0);                                   // cycle 1: req pc 4
        step(0, 0, 1, 32'h0000_0040);                       // cycle 2: jump
        check_eq("j_req_blocked", {31'd0, rom_req}, 32'd0);
        step(0, 1, 0, 0);                                   // t+1
        check_eq("j_t1_addr",  rom_addr, 32'h40);
        check_eq("j_t1_req",   {31'd0, rom_req}, 32'd1);
        check_eq("j_t1_valid", {31'd0, if_valid}, 32'd0);
        step(0, 1, 0, 0);                                   // t+2
        check_eq("j_t2_valid", {31'd0, if_valid}, 32'd0);
        check_eq("j_t2_addr",  rom_addr, 32'h44);
        step(0, 1, 0, 0);                                   // t+3
        expect_head("j_t3", 32'h40, 32'hC000_0040);

        // Redirect coinciding with a push and a pop; misaligned target
        step(0, 1, 1, 32'h0000_0013);
        check_eq("jp_valid_same", {31'd0, if_valid}, 32'd1);
        check_eq("jp_pc_same",    if_pc, 32'h44);
        step(0, 1, 0, 0);
        check_eq("jp_count",  32'(dut.fifo_count), 32'd0);
        check_eq("jp_addr",   rom_addr, 32'h10);
        step(0, 1, 0, 0);
        check_eq("jp_valid1", {31'd0, if_valid}, 32'd0);
        step(0, 1, 0, 0);
        expect_head("jp_h0", 32'h10, 32'hC000_0010);
        step(0, 1, 0, 0);
        expect_head("jp_h1", 32'h14, 32'hC000_0014);

        // Reset mid-stream while fetching 0x20
        step(0, 1, 0, 0);
        check_eq("mr_addr_pre", rom_addr, 32'h20);
        step(1, 1, 0, 0);
        check_eq("mr_req_rst", {31'd0, rom_req}, 32'd0);
        step(0, 1, 0, 0);
        check_eq("mr_valid0", {31'd0, if_valid}, 32'd0);
        check_eq("mr_addr0",  rom_addr, 32'h0);
        check_eq("mr_req0",   {31'd0, rom_req}, 32'd1);
        step(0, 1, 0, 0);
        check_eq("mr_valid1", {31'd0, if_valid}, 32'd0);
        step(0, 1, 0, 0);
        expect_head("mr_h0", 32'h0, 32'h11);

        // PC wrap at the top of the address space
        step(0, 1, 1, 32'hFFFF_FFFE);
        step(0, 1, 0, 0);
        check_eq("wr_addr_top", rom_addr, 32'hFFFF_FFFC);
        step(0, 1, 0, 0);
        check_eq("wr_addr_wrap", rom_addr, 32'h0);
        step(0, 1, 0, 0);
        expect_head("wr_h0", 32'hFFFF_FFFC, 32'hC0FF_FFFC);
        step(0, 1, 0, 0);
        expect_head("wr_h1", 32'h0, 32'h11);

        // Held redirect: every cycle reloads pc, fetch resumes after the last
        step(0, 1, 1, 32'h0000_0100);
        check_eq("hj0_req", {31'd0, rom_req}, 32'd0);
        step(0, 1, 1, 32'h0000_0200);
        check_eq("hj1_req",  {31'd0, rom_req}, 32'd0);
        check_eq("hj1_addr", rom_addr, 32'h100);
        step(0, 1, 0, 0);
        check_eq("hj2_addr", rom_addr, 32'h200);
        check_eq("hj2_req",  {31'd0, rom_req}, 32'd1);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        expect_head("hj_h0", 32'h200, 32'hC000_0200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
